muldiv_unit: RTL and testbench

- Iterative multiply/divide unit sitting beside the ALU in the EX stage.
- Driven by the same R-type funct field that the ALU control path decodes.
- Owns the HI/LO register pair and executes MULT/MULTU/DIV/DIVU over multiple cycles.
- Raises busy so hazard logic stalls the pipeline; serves MFHI/MFLO/MTHI/MTLO.

---
 rtl/muldiv_unit.sv | 215 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine owning HI/LO, plus MFHI/MFLO/MTHI/MTLO.
// Optional macro MULDIV_EARLY_EXIT_EN: MUL stops once the remaining multiplier bits are all zero.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_out
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0]   plier_q, plier_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               is_mul_op, is_div_op, is_signed;
  logic               accept_md, accept_mt;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               last_iter, mul_last;
  logic [WIDTH-1:0]   plier_shift;
  logic [WIDTH:0]     div_shifted, div_diff;
  logic [WIDTH-1:0]   div_rem_next;
  logic [WIDTH-1:0]   quo, rem;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  // Decode and operand conditioning for the accepting cycle
  always_comb begin
    is_mul_op = (funct == F_MULT) || (funct == F_MULTU);
    is_div_op = (funct == F_DIV)  || (funct == F_DIVU);
    is_signed = (funct == F_MULT) || (funct == F_DIV);
    accept_md = start && (state_q == S_IDLE) && (is_mul_op || is_div_op);
    accept_mt = start && (state_q == S_IDLE) && ((funct == F_MTHI) || (funct == F_MTLO));
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];
    a_mag     = a_neg ? ('0 - a) : a;
    b_mag     = b_neg ? ('0 - b) : b;
  end

  // Iteration datapath
  always_comb begin
    last_iter    = (cnt_q == CNT_W'(1));
    plier_shift  = plier_q >> 1;
`ifdef MULDIV_EARLY_EXIT_EN
    mul_last     = last_iter || (plier_shift == '0);
`else
    mul_last     = last_iter;
`endif
    div_shifted  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff     = div_shifted - {1'b0, opnd_q[WIDTH-1:0]};
    div_rem_next = div_diff[WIDTH] ? div_shifted[WIDTH-1:0] : div_diff[WIDTH-1:0];
  end

  // Sign correction applied in FIX; divide-by-zero bypasses the magnitude result
  always_comb begin
    quo        = acc_q[WIDTH-1:0];
    rem        = acc_q[2*WIDTH-1:WIDTH];
    prod_fixed = qneg_q ? ('0 - acc_q) : acc_q;
    if (!is_div_q) begin
      fix_hi = prod_fixed[2*WIDTH-1:WIDTH];
      fix_lo = prod_fixed[WIDTH-1:0];
    end else if (opnd_q[WIDTH-1:0] == '0) begin
      fix_hi = a_raw_q;
      fix_lo = '1;
    end else begin
      fix_hi = rneg_q ? ('0 - rem) : rem;
      fix_lo = qneg_q ? ('0 - quo) : quo;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_md) state_d = is_div_op ? S_DIV : S_MUL;
      S_MUL:   if (mul_last) state_d = S_FIX;
      S_DIV:   if (last_iter) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
    if (funct == F_MFHI)      mf_out = hi_q;
    else if (funct == F_MFLO) mf_out = lo_q;
    else                      mf_out = '0;
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    plier_d  = plier_q;
    a_raw_d  = a_raw_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = (state_q == S_FIX);
    case (state_q)
      S_IDLE: begin
        if (accept_md) begin
          cnt_d    = CNT_W'(WIDTH);
          a_raw_d  = a;
          qneg_d   = a_neg ^ b_neg;
          rneg_d   = a_neg;
          is_div_d = is_div_op;
          if (is_div_op) begin
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            opnd_d  = {{WIDTH{1'b0}}, b_mag};
            plier_d = '0;
          end else begin
            acc_d   = '0;
            opnd_d  = {{WIDTH{1'b0}}, a_mag};
            plier_d = b_mag;
          end
        end else if (accept_mt) begin
          if (funct == F_MTHI) hi_d = a;
          else                 lo_d = a;
        end
      end
      S_MUL: begin
        cnt_d   = cnt_q - CNT_W'(1);
        acc_d   = acc_q + (plier_q[0] ? opnd_q : '0);
        opnd_d  = opnd_q << 1;
        plier_d = plier_shift;
      end
      S_DIV: begin
        cnt_d = cnt_q - CNT_W'(1);
        acc_d = {div_rem_next, acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
      end
      S_FIX: begin
        cnt_d = '0;
        hi_d  = fix_hi;
        lo_d  = fix_lo;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      plier_q  <= '0;
      a_raw_q  <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      plier_q  <= plier_d;
      a_raw_q  <= a_raw_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// tb_muldiv_unit: directed and random stimulus against an arithmetic reference model of HI/LO.
module tb_muldiv_unit;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  funct = 6'h00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi, lo, mf_out;

  int vectors = 0;
  int errs = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .funct(funct), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .mf_out(mf_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, sq, sr;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (f)
      F_MULTU: p = {32'd0, x} * {32'd0, y};
      F_MULT:  p = 64'(sx * sy);
      F_DIVU:  p = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      default: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else begin
          sq = sx / sy;
          sr = sx % sy;
          p = {sr[31:0], sq[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  function automatic int exp_busy(input logic [5:0] f, input logic [31:0] y);
    int it;
    it = 32;
`ifdef MULDIV_EARLY_EXIT_EN
    if (f == F_MULT || f == F_MULTU) begin
      logic [31:0] m;
      m = (f == F_MULT && y[31]) ? (32'd0 - y) : y;
      it = 1;
      for (int i = 0; i < 32; i++) if (m[i]) it = i + 1;
    end
`endif
    return it + 1;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Called at negedge+1 of an IDLE cycle; returns in the done cycle when chain=1
  task automatic do_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                       input bit inject, input bit chain);
    logic [63:0] r;
    int n;
    r = ref_md(f, x, y);
    start = 1'b1; funct = f; a = x; b = y;
    step();
    start = 1'b0; funct = F_MFLO;
    #1;
    chk("mflo_while_busy", {32'd0, mf_out}, {32'd0, m_lo});
    if (inject) begin
      start = 1'b1; funct = F_DIVU; a = $urandom; b = $urandom;
    end
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      step();
      start = 1'b0; funct = F_MFHI;
      #1;
    end
    chk("busy_cycles", 64'(n), 64'(exp_busy(f, y)));
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("hi_lo", {hi, lo}, r);
    chk("mfhi_result", {32'd0, mf_out}, {32'd0, r[63:32]});
    m_hi = r[63:32];
    m_lo = r[31:0];
    if (!chain) begin
      step();
      chk("done_one_cycle", {62'd0, busy, done}, 64'd0);
    end
  endtask

  initial begin
    logic        seen_done;
    logic [5:0]  f;
    logic [31:0] x, y;
    logic [5:0]  ops [4];
    ops[0] = F_MULT; ops[1] = F_MULTU; ops[2] = F_DIV; ops[3] = F_DIVU;

    #12;
    chk("reset_state", {28'd0, busy, done, 2'b00, hi, lo}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    do_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(F_MULTU, 32'h1234_5678, 32'd3, 1'b0, 1'b0);
    do_op(F_MULT, 32'hFFFF_FFF9, 32'd3, 1'b0, 1'b0);
    do_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    do_op(F_DIVU, 32'd7, 32'd0, 1'b0, 1'b0);
    do_op(F_DIV, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
    do_op(F_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(F_MULT, 32'd5, 32'd0, 1'b0, 1'b0);

    // MTHI / MTLO write at the accepting edge without busy
    start = 1'b1; funct = F_MTHI; a = 32'h1234_5678;
    step();
    start = 1'b0; funct = F_MFHI;
    #1;
    chk("mthi_mfhi", {31'd0, busy, mf_out}, {32'd0, 32'h1234_5678});
    m_hi = 32'h1234_5678;
    start = 1'b1; funct = F_MTLO; a = 32'hCAFE_F00D;
    step();
    start = 1'b0; funct = F_MFLO;
    #1;
    chk("mtlo_mflo", {31'd0, busy, mf_out}, {32'd0, 32'hCAFE_F00D});
    m_lo = 32'hCAFE_F00D;
    funct = F_MULT;
    #1;
    chk("mf_out_other", {32'd0, mf_out}, 64'd0);

    // Unrecognised funct with start is ignored
    start = 1'b1; funct = 6'h20; a = 32'hDEAD_BEEF; b = 32'h1;
    step();
    start = 1'b0;
    chk("ignored_funct", {31'd0, busy, hi, lo}, {32'd0, m_hi, m_lo} | 64'd0);
    step();
    chk("ignored_no_done", {63'd0, done}, 64'd0);

    // MFLO during DIV shows the old LO; DIVU issued while busy is dropped
    do_op(F_DIV, 32'd100, 32'hFFFF_FFFD, 1'b0, 1'b0);
    do_op(F_MULT, 32'hFFFF_0001, 32'h0001_2345, 1'b1, 1'b0);

    // Back-to-back: the next MULT is issued in the done cycle
    do_op(F_MULTU, 32'hABCD_0123, 32'h0000_00FF, 1'b0, 1'b1);
    do_op(F_MULT, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1);
    do_op(F_DIVU, 32'hFFFF_FFFF, 32'd10, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      f = ops[$urandom_range(0, 3)];
      x = $urandom;
      case ($urandom_range(0, 3))
        0:       y = 32'd0;
        1:       y = $urandom_range(1, 15);
        2:       y = 32'd0 - $urandom_range(1, 15);
        default: y = $urandom;
      endcase
      do_op(f, x, y, k[0], k[1]);
    end
    step();

    // Reset in busy cycle 10 of a MULT aborts it without a HI/LO write
    start = 1'b1; funct = F_MULT; a = 32'h0000_1234; b = 32'h0000_5678;
    step();
    start = 1'b0;
    for (int i = 1; i < 10; i++) step();
    chk("busy_before_reset", {63'd0, busy}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset", {30'd0, busy, done, hi, lo}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      seen_done |= done | busy;
    end
    chk("no_done_after_reset", {63'd0, seen_done}, 64'd0);
    chk("hilo_after_reset", {hi, lo}, {m_hi, m_lo});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
